io_fifo_channel: RTL

Parametrised, synthesizable input channel between a host/testbench byte source and the bfX core's input instruction. Host pushes words into an internal FIFO with valid/ready. The core fetches one word per request through a request/valid handshake with a configurable artificial delay, and gets a fixed EOF value when the source is exhausted. It replaces fixed-size, file-loaded, unclocked input queues with a clocked, resettable buffer.

---
 rtl/io_fifo_channel.sv | 95 +++++++++
 1 files changed

// File: rtl/io_fifo_channel.sv
// io_fifo_channel: FIFO input channel with delayed request/valid fetch and EOF; IO_FIFO_STATS_EN adds stat counters
module io_fifo_channel #(
    parameter int DATA_W = 8,
    parameter int DEPTH = 128,
    parameter int LATENCY = 4,
    parameter logic [DATA_W-1:0] EOF_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       eof_in,
    input  logic                       rd_req,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
`ifdef IO_FIFO_STATS_EN
    ,
    output logic [31:0]                stat_pops,
    output logic [15:0]                stat_drops
`endif
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
    state_t state, state_n;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0] dly, dly_n;
    logic push, pop, take_eof;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign wr_ready = !full;
    assign push = wr_valid && wr_ready;
    assign rd_valid = state == HOLD;
    always_comb begin
        state_n = state;
        dly_n = dly;
        pop = 1'b0;
        take_eof = 1'b0;
        case (state)
            IDLE: if (rd_req) begin
                state_n = WAIT;
                dly_n = 8'(LATENCY);
            end
            WAIT: if (dly != 8'd0) dly_n = dly - 8'd1;
            else if (!empty) begin
                pop = 1'b1;
                state_n = HOLD;
            end else if (eof_in) begin
                take_eof = 1'b1;
                state_n = HOLD;
            end
            HOLD: if (rd_req) begin
                state_n = WAIT;
                dly_n = 8'(LATENCY);
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) if (push) mem[wr_ptr] <= wr_data;
    // pop reads the pre-edge head, so a same-cycle push can never be the popped word
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            dly <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            rd_data <= '0;
        end else begin
            state <= state_n;
            dly <= dly_n;
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            rd_data <= pop ? mem[rd_ptr] : take_eof ? EOF_VAL : rd_data;
        end
    end
`ifdef IO_FIFO_STATS_EN
    logic [16:0] drop_sum;
    assign drop_sum = {1'b0, stat_drops} + 17'(wr_valid && full) + 17'(rd_req && state == WAIT);
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pops <= '0;
            stat_drops <= '0;
        end else begin
            stat_pops <= stat_pops + 32'(pop);
            stat_drops <= drop_sum[16] ? '1 : drop_sum[15:0];
        end
    end
`endif
endmodule
